// File: rtl/rv523_bist_pkg.sv
// Shared definitions for the standard-cell BIST: cell codes, FSM states and
// the golden truth functions (also reused by the library testbenches).
package rv523_bist_pkg;

  typedef enum logic [3:0] {
    CELL_NOT    = 4'd0,
    CELL_NAND   = 4'd1,
    CELL_NOR    = 4'd2,
    CELL_NAND3  = 4'd3,
    CELL_NOR3   = 4'd4,
    CELL_AOI21  = 4'd5,
    CELL_OAI21  = 4'd6,
    CELL_AOI22  = 4'd7,
    CELL_OAI22  = 4'd8,
    CELL_AOI211 = 4'd9,
    CELL_OAI211 = 4'd10
  } cell_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CELL_MAX = 4'd10;

  // Number of inputs of a cell.
  function automatic logic [2:0] cell_inputs(input cell_t c);
    logic [2:0] n;
    case (c)
      CELL_NOT:                                   n = 3'd1;
      CELL_NAND, CELL_NOR:                        n = 3'd2;
      CELL_NAND3, CELL_NOR3, CELL_AOI21, CELL_OAI21: n = 3'd3;
      default:                                    n = 3'd4;
    endcase
    return n;
  endfunction

  // Last input vector applied to a cell: 2^n - 1.
  function automatic logic [3:0] last_vec(input cell_t c);
    logic [3:0] v;
    case (cell_inputs(c))
      3'd1:    v = 4'd1;
      3'd2:    v = 4'd3;
      3'd3:    v = 4'd7;
      default: v = 4'd15;
    endcase
    return v;
  endfunction

  // Golden output of a cell for an input vector in pin order.
  function automatic logic cell_eval(input cell_t c, input logic [3:0] v);
    logic y;
    case (c)
      CELL_NOT:    y = ~v[0];
      CELL_NAND:   y = ~(v[0] & v[1]);
      CELL_NOR:    y = ~(v[0] | v[1]);
      CELL_NAND3:  y = ~(v[0] & v[1] & v[2]);
      CELL_NOR3:   y = ~(v[0] | v[1] | v[2]);
      CELL_AOI21:  y = ~(v[0] | (v[1] & v[2]));
      CELL_OAI21:  y = ~(v[0] & (v[1] | v[2]));
      CELL_AOI22:  y = ~((v[0] & v[1]) | (v[2] & v[3]));
      CELL_OAI22:  y = ~((v[0] | v[1]) & (v[2] | v[3]));
      CELL_AOI211: y = ~(v[0] | v[1] | (v[2] & v[3]));
      CELL_OAI211: y = ~(v[0] & v[1] & (v[2] | v[3]));
      default:     y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/cell_bist_sync2.sv
// Two-flop synchronizer for the asynchronous cell output.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cell_bist.sv
// BIST sequencer: walks every input vector of the selected cell, compares the
// synchronized cell output with the golden model and records the verdict.
module cell_bist
  import rv523_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] cell_sel,
  output logic [3:0] dut_in,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       bad_sel,
  output logic [4:0] err_count,
  output logic [3:0] first_fail_vec,
  output logic       first_fail_valid
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  cell_t      cell_sel_q;
  logic [3:0] vec;
  logic [3:0] cnt;
  logic       y_s;
  logic       mismatch;
  logic [4:0] err_next;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_y),
    .q     (y_s)
  );

  // Compare the sampled output with the golden value for the current vector.
  always_comb begin
    mismatch = (y_s != cell_eval(cell_sel_q, vec));
    err_next = err_count + {4'b0000, mismatch};
  end

  // Sequencer FSM and result registers.
  // pass is resolved on the CHECK->DONE edge from err_next so it is already
  // valid in the done cycle, including a mismatch on the last vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      cell_sel_q       <= CELL_NOT;
      vec              <= '0;
      cnt              <= '0;
      pass             <= 1'b0;
      bad_sel          <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cell_sel <= CELL_MAX) begin
              cell_sel_q       <= cell_t'(cell_sel);
              vec              <= '0;
              err_count        <= '0;
              first_fail_valid <= 1'b0;
              bad_sel          <= 1'b0;
              pass             <= 1'b0;
              cnt              <= CNT_LOAD;
              state            <= ST_SETTLE;
            end else begin
              bad_sel <= 1'b1;
              pass    <= 1'b0;
              state   <= ST_DONE;
            end
          end
        end
        ST_SETTLE: begin
          if (cnt == 4'd0) begin
            state <= ST_CHECK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_CHECK: begin
          if (mismatch) begin
            err_count <= err_next;
            if (!first_fail_valid) begin
              first_fail_vec   <= vec;
              first_fail_valid <= 1'b1;
            end
          end
          if (vec == last_vec(cell_sel_q)) begin
            pass  <= (err_next == 5'd0) && !bad_sel;
            vec   <= '0;
            state <= ST_DONE;
          end else begin
            vec   <= vec + 4'd1;
            cnt   <= CNT_LOAD;
            state <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          vec   <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    dut_in = vec;
    busy   = (state != ST_IDLE);
    done   = (state == ST_DONE);
  end

endmodule

// File: tb/tb_cell_bist.sv
// Directed bench for cell_bist with behavioural cell models on dut_y.
module tb_cell_bist;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] cell_sel;
  logic [3:0] dut_in;
  logic       dut_y;
  logic       busy;
  logic       done;
  logic       pass;
  logic       bad_sel;
  logic [4:0] err_count;
  logic [3:0] first_fail_vec;
  logic       first_fail_valid;

  int total;
  int bad;

  // Cell model selection for dut_y
  localparam int M_NAND = 0, M_AOI22_B2SA0 = 1, M_ONE = 2, M_OAI211 = 3, M_NOR3 = 4;
  int mode;

  logic [3:0] seen [0:255];
  logic       busy0;

  cell_bist #(.SETTLE_CYCLES(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .cell_sel         (cell_sel),
    .dut_in           (dut_in),
    .dut_y            (dut_y),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .bad_sel          (bad_sel),
    .err_count        (err_count),
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    dut_y = 1'b0;
    case (mode)
      M_NAND:        dut_y = ~(dut_in[0] & dut_in[1]);
      M_AOI22_B2SA0: dut_y = ~(dut_in[0] & dut_in[1]);
      M_ONE:         dut_y = 1'b1;
      M_OAI211:      dut_y = ~(dut_in[0] & dut_in[1] & (dut_in[2] | dut_in[3]));
      M_NOR3:        dut_y = ~(dut_in[0] | dut_in[1] | dut_in[2]);
      default:       dut_y = 1'b0;
    endcase
  end

  // Start a test and follow it; lat = edges after the start edge at which done
  // is first seen (-1 if never), pulses = number of done cycles observed.
  task automatic run_test(input logic [3:0] sel, input int pulse_off,
                          output int lat, output int pulses);
    @(negedge clk);
    cell_sel = sel;
    start = 1'b1;
    @(posedge clk);
    #1;
    seen[0] = dut_in;
    busy0 = busy;
    lat = -1;
    pulses = 0;
    if (done) begin
      lat = 0;
      pulses = 1;
    end
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (i == pulse_off + 1) start = 1'b0;
      seen[i] = dut_in;
      if (done) begin
        pulses++;
        if (lat < 0) lat = i;
      end
      if (i == pulse_off) start = 1'b1;
      if (lat >= 0 && i >= lat + 2) break;
    end
  endtask

  task automatic test_reset;
    total++;
    if ({dut_in, busy, done, pass, bad_sel, err_count, first_fail_vec, first_fail_valid} !== 17'd0) begin
      bad++;
      $display("FAIL reset_outputs: got dut_in=%0d busy=%b done=%b pass=%b bad_sel=%b err=%0d ffv=%0d ffvalid=%b, want all 0",
               dut_in, busy, done, pass, bad_sel, err_count, first_fail_vec, first_fail_valid);
    end
  endtask

  task automatic test_nand_ideal;
    int lat, pulses;
    mode = M_NAND;
    run_test(4'd1, -10, lat, pulses);
    total++;
    if (busy0 !== 1'b1 || seen[0] !== 4'd0) begin
      bad++;
      $display("FAIL nand_start: busy=%b dut_in=%0d, want busy=1 dut_in=0", busy0, seen[0]);
    end
    total++;
    if (lat !== 20) begin bad++; $display("FAIL nand_done_time: got %0d want 20", lat); end
    total++;
    if (pulses !== 1) begin bad++; $display("FAIL nand_done_width: got %0d want 1", pulses); end
    for (int m = 0; m < 4; m++) begin
      total++;
      if (seen[5*m+1] !== 4'(m)) begin
        bad++;
        $display("FAIL nand_vector_%0d: dut_in=%0d want %0d", m, seen[5*m+1], m);
      end
    end
    total++;
    if (pass !== 1'b1 || err_count !== 5'd0 || first_fail_valid !== 1'b0 || busy !== 1'b0 || dut_in !== 4'd0) begin
      bad++;
      $display("FAIL nand_result: pass=%b err=%0d ffvalid=%b busy=%b dut_in=%0d want 1 0 0 0 0",
               pass, err_count, first_fail_valid, busy, dut_in);
    end
  endtask

  task automatic test_aoi22_stuck;
    int lat, pulses;
    mode = M_AOI22_B2SA0;
    run_test(4'd7, -10, lat, pulses);
    total++;
    if (lat !== 80) begin bad++; $display("FAIL aoi22_done_time: got %0d want 80", lat); end
    total++;
    if (err_count !== 5'd3 || first_fail_vec !== 4'd12 || first_fail_valid !== 1'b1 || pass !== 1'b0) begin
      bad++;
      $display("FAIL aoi22_result: err=%0d ffv=%0d ffvalid=%b pass=%b want 3 12 1 0",
               err_count, first_fail_vec, first_fail_valid, pass);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (err_count !== 5'd3 || first_fail_vec !== 4'd12 || pass !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL aoi22_held: err=%0d ffv=%0d pass=%b busy=%b want 3 12 0 0",
               err_count, first_fail_vec, pass, busy);
    end
  endtask

  task automatic test_not_stuck_high;
    int lat, pulses;
    mode = M_ONE;
    run_test(4'd0, -10, lat, pulses);
    total++;
    if (lat !== 10) begin bad++; $display("FAIL not_done_time: got %0d want 10", lat); end
    total++;
    if (err_count !== 5'd1 || first_fail_vec !== 4'd1 || first_fail_valid !== 1'b1 || pass !== 1'b0) begin
      bad++;
      $display("FAIL not_result: err=%0d ffv=%0d ffvalid=%b pass=%b want 1 1 1 0",
               err_count, first_fail_vec, first_fail_valid, pass);
    end
  endtask

  task automatic test_bad_sel;
    int lat, pulses;
    mode = M_NAND;
    run_test(4'd13, -10, lat, pulses);
    total++;
    if (lat !== 0 || pulses !== 1) begin
      bad++;
      $display("FAIL badsel_done: lat=%0d pulses=%0d want 0 1", lat, pulses);
    end
    total++;
    if (bad_sel !== 1'b1 || pass !== 1'b0) begin
      bad++;
      $display("FAIL badsel_flags: bad_sel=%b pass=%b want 1 0", bad_sel, pass);
    end
    total++;
    if (seen[0] !== 4'd0 || seen[1] !== 4'd0 || dut_in !== 4'd0) begin
      bad++;
      $display("FAIL badsel_dut_in: %0d %0d %0d want 0 0 0", seen[0], seen[1], dut_in);
    end
  endtask

  task automatic test_start_ignored;
    int lat, pulses;
    mode = M_OAI211;
    run_test(4'd10, 23, lat, pulses);
    total++;
    if (lat !== 80 || pulses !== 1) begin
      bad++;
      $display("FAIL oai211_done: lat=%0d pulses=%0d want 80 1", lat, pulses);
    end
    total++;
    if (pass !== 1'b1 || err_count !== 5'd0 || bad_sel !== 1'b0) begin
      bad++;
      $display("FAIL oai211_result: pass=%b err=%0d bad_sel=%b want 1 0 0", pass, err_count, bad_sel);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int k2;
    mode = M_NAND;
    @(negedge clk);
    cell_sel = 4'd1;
    start = 1'b1;
    lat = -1;
    k2 = -1;
    for (int i = 0; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done && lat < 0) lat = i;
      if (lat >= 0 && i == lat + 2) k2 = (busy && dut_in == 4'd0) ? 1 : 0;
    end
    start = 1'b0;
    total++;
    if (lat !== 20 || k2 !== 1) begin
      bad++;
      $display("FAIL held_start_restart: first done at %0d restart=%0d want 20 1", lat, k2);
    end
    repeat (30) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || pass !== 1'b1) begin
      bad++;
      $display("FAIL held_start_second: busy=%b pass=%b want 0 1", busy, pass);
    end
  endtask

  task automatic test_reset_abort;
    int lat, pulses;
    int dcount;
    mode = M_NOR3;
    dcount = 0;
    @(negedge clk);
    cell_sel = 4'd4;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 26; i++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    total++;
    if (dut_in !== 4'd5 || busy !== 1'b1) begin
      bad++;
      $display("FAIL nor3_at_vec5: dut_in=%0d busy=%b want 5 1", dut_in, busy);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({dut_in, busy, done, pass, bad_sel, err_count, first_fail_vec, first_fail_valid} !== 17'd0) begin
      bad++;
      $display("FAIL abort_outputs: dut_in=%0d busy=%b done=%b pass=%b bad_sel=%b err=%0d ffv=%0d ffvalid=%b want all 0",
               dut_in, busy, done, pass, bad_sel, err_count, first_fail_vec, first_fail_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (dcount !== 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", dcount); end
    run_test(4'd4, -10, lat, pulses);
    total++;
    if (lat !== 40 || pass !== 1'b1 || err_count !== 5'd0) begin
      bad++;
      $display("FAIL nor3_rerun: lat=%0d pass=%b err=%0d want 40 1 0", lat, pass, err_count);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    mode = M_NAND;
    rst_n = 1'b0;
    start = 1'b0;
    cell_sel = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    test_nand_ideal;
    test_aoi22_stuck;
    test_not_stuck_high;
    test_bad_sel;
    test_start_ignored;
    test_back_to_back;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
